bcd_seq_adder: RTL and testbench

Multi-cycle N-digit packed-BCD adder controller.
- Accepts two DIGITS-digit BCD operands through a valid/ready handshake.
- Processes one two-digit (8-bit) pair per cycle through a shared combinational BCD pair adder, least-significant pair first, with a registered decimal carry chain.
- Presents the result through an output valid/ready handshake.
- Serves as the wide decimal arithmetic front-end built on the 8-bit BCD adder datapath.

---
 rtl/bcd_seq_pkg.sv | 25 ++
 rtl/bcd_seq_adder_pair.sv | 39 +++
 rtl/bcd_seq_adder.sv | 149 ++++++++++++++
 tb/tb_bcd_seq_adder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_pkg.sv
// Shared definitions for the sequential packed-BCD adder.
// Holds the FSM state type, the BCD digit constants and small digit helpers.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  // Nine's complement of a single BCD digit (used to turn A+B into A-B).
  function automatic logic [DIGIT_W-1:0] bcd_nines(input logic [DIGIT_W-1:0] digit);
    return DIGIT_W'(BCD_MAX) - digit;
  endfunction

  // True when a 4-bit code is not a legal decimal digit.
  function automatic logic bcd_bad(input logic [DIGIT_W-1:0] digit);
    return digit > DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_seq_adder_pair.sv
// Combinational two-digit BCD adder shared by the sequential controller.
// Low digit first, its decimal carry ripples into the high digit.
module bcd_pair_add
  import bcd_seq_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Single-digit decimal add; returns {carry, digit}. Codes above 9 are
  // still corrected the same way so the output stays deterministic.
  function automatic logic [DIGIT_W:0] digit_add(input logic [DIGIT_W-1:0] x,
                                                 input logic [DIGIT_W-1:0] y,
                                                 input logic             c);
    logic [DIGIT_W:0] s;
    logic [DIGIT_W:0] t;
    s = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, c};
    t = s + (DIGIT_W+1)'(BCD_CORR);
    if (s > (DIGIT_W+1)'(BCD_MAX)) begin
      return {1'b1, t[DIGIT_W-1:0]};
    end
    return {1'b0, s[DIGIT_W-1:0]};
  endfunction

  logic [DIGIT_W:0] lo;
  logic [DIGIT_W:0] hi;

  // Ripple the decimal carry from the low digit into the high digit.
  always_comb begin
    lo   = digit_add(a[3:0], b[3:0], cin);
    hi   = digit_add(a[7:4], b[7:4], lo[DIGIT_W]);
    sum  = {hi[DIGIT_W-1:0], lo[DIGIT_W-1:0]};
    cout = hi[DIGIT_W];
  end

endmodule

// File: rtl/bcd_seq_adder.sv
// Multi-cycle packed-BCD adder: one digit pair per cycle through a shared
// pair adder, LS pair first, with a registered decimal carry.
// Optional build macro: BCD_SUB_EN enables A-B via nine's complement of B.
module bcd_seq_adder
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   op_a,
  input  logic [4*DIGITS-1:0]   op_b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int PAIRS = DIGITS / 2;
  localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAIRS - 1);

  state_t           state;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;
  logic [W-1:0]     res_r;
  logic [W-1:0]     res_shift;
  logic [CNT_W-1:0] cnt;
  logic             carry_r;
  logic             cout_r;
  logic             err_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [W-1:0]     b_cap;
  logic             carry_cap;
  logic             any_bad;
  logic [7:0]       pair_sum;
  logic             pair_cout;

  // Operand conditioning at capture: digit validity and optional complement.
  always_comb begin
    any_bad   = 1'b0;
    b_cap     = op_b;
    carry_cap = cin;
    for (int i = 0; i < DIGITS; i++) begin
      any_bad = any_bad | bcd_bad(op_a[DIGIT_W*i +: DIGIT_W])
                        | bcd_bad(op_b[DIGIT_W*i +: DIGIT_W]);
    end
`ifdef BCD_SUB_EN
    if (sub) begin
      for (int i = 0; i < DIGITS; i++) begin
        b_cap[DIGIT_W*i +: DIGIT_W] = bcd_nines(op_b[DIGIT_W*i +: DIGIT_W]);
      end
      carry_cap = 1'b1;
    end
`endif
  end

`ifndef BCD_SUB_EN
  logic unused_sub;
  assign unused_sub = sub;
`endif

  // New pair enters at the top of the result register; the LS pair ends up
  // at the bottom after PAIRS shifts.
  generate
    if (PAIRS == 1) begin : g_res_one
      assign res_shift = pair_sum;
    end else begin : g_res_many
      assign res_shift = {pair_sum, res_r[W-1:8]};
    end
  endgenerate

  bcd_pair_add u_pair (
    .a    (a_sr[7:0]),
    .b    (b_sr[7:0]),
    .cin  (carry_r),
    .sum  (pair_sum),
    .cout (pair_cout)
  );

  // Control FSM and datapath registers, with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      res_r       <= '0;
      cnt         <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr       <= op_a;
            b_sr       <= b_cap;
            carry_r    <= carry_cap;
            cnt        <= '0;
            err_r      <= any_bad;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 8;
          b_sr    <= b_sr >> 8;
          res_r   <= res_shift;
          carry_r <= pair_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_r      <= pair_cout;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = res_r;
  assign cout      = cout_r;
  assign err       = err_r;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder (DIGITS=8): directed cases plus
// randomized operations checked against a decimal-arithmetic reference.
module tb_bcd_seq_adder;

  localparam int DIGITS = 8;
  localparam int W      = 4 * DIGITS;
  localparam int PAIRS  = DIGITS / 2;
  localparam longint MOD = 64'd100000000;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         err;

  int checks = 0;
  int errors = 0;

  bcd_seq_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic for legal operands; for illegal
  // codes, apply the digit rule digit by digit (s>9 -> +6 mod 16, carry).
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic s,
                                output logic [W-1:0] r, output logic co, output logic e);
    longint va, vb, tot;
    int     dc, ds;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) e = 1'b1;
    va = bcd2int(a);
    vb = bcd2int(b);
`ifdef BCD_SUB_EN
    if (s) begin
      tot = va - vb;
      co  = (va >= vb);
      if (tot < 0) tot = tot + MOD;
      r = int2bcd(tot);
      return;
    end
`endif
    if (!e) begin
      tot = va + vb + longint'(c);
      co  = (tot >= MOD);
      r   = int2bcd(tot % MOD);
    end else begin
      dc = int'(c);
      r  = '0;
      for (int i = 0; i < DIGITS; i++) begin
        ds = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + dc;
        if (ds > 9) begin
          r[4*i +: 4] = 4'((ds + 6) % 16);
          dc = 1;
        end else begin
          r[4*i +: 4] = 4'(ds);
          dc = 0;
        end
      end
      co = dc[0];
    end
    if (s) co = co;
  endfunction

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      chk({tag, "_busy_rdy"}, in_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, PAIRS);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input int hold,
                        input logic [W-1:0] er, input logic ec, input logic ee,
                        input string tag);
    logic [W-1:0] snap;
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk({tag, "_rdy_timeout"}, in_ready, 1'b1);
    op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(tag);
    snap = result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_res"}, result, snap);
      chk({tag, "_hold_vld"}, out_valid, 1'b1);
      chk({tag, "_hold_rdy"}, in_ready, 1'b0);
    end
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_err"}, err, ee);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, out_valid, 1'b0);
    chk({tag, "_rdy_rise"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         rc, rs, ec, ee;

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h12345678, 32'h87654321, 1'b0, 1'b0, 0, 32'h99999999, 1'b0, 1'b0, "nines");
    run_op(32'h99999999, 32'h00000001, 1'b0, 1'b0, 0, 32'h00000000, 1'b1, 1'b0, "wrap");
    run_op(32'h00000005, 32'h00000005, 1'b1, 1'b0, 0, 32'h00000011, 1'b0, 1'b0, "cin");

    // Backpressure with a competing request held high through DONE.
    op_a = 32'h12345678; op_b = 32'h87654321; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 32'h00000001; op_b = 32'h00000001;
    wait_out("bp");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_res", result, 32'h99999999);
      chk("bp_vld", out_valid, 1'b1);
      chk("bp_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_not_taken_rdy", in_ready, 1'b1);
    chk("bp_not_taken_vld", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_taken", in_ready, 1'b0);
    wait_out("bp2");
    chk("bp2_res", result, 32'h00000002);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in the second RUN cycle.
    op_a = 32'h12345678; op_b = 32'h87654321; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_rdy", in_ready, 1'b1);
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_res", result, '0);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("arst_no_vld", out_valid, 1'b0);
    end
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 0, 32'h00000002, 1'b0, 1'b0, "post_rst");

    run_op(32'h0000000A, 32'h00000000, 1'b0, 1'b0, 1, 32'h00000010, 1'b0, 1'b1, "bad_digit");
    run_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, 0, 32'h00000003, 1'b0, 1'b0, "err_clear");

`ifdef BCD_SUB_EN
    run_op(32'h00001000, 32'h00000001, 1'b0, 1'b1, 0, 32'h00000999, 1'b1, 1'b0, "sub_pos");
    run_op(32'h00000000, 32'h00000001, 1'b0, 1'b1, 0, 32'h99999999, 1'b0, 1'b0, "sub_neg");
`else
    run_op(32'h00001000, 32'h00000001, 1'b0, 1'b1, 0, 32'h00001001, 1'b0, 1'b0, "sub_ignored");
`endif

    for (int t = 0; t < 40; t++) begin
      ra = '0; rb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (t % 8 == 7) begin
        ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        rs = 1'b0;
      end
      model(ra, rb, rc, rs, er, ec, ee);
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 2)), er, ec, ee, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
